// File: rtl/tm1638_led_writer.sv
`default_nettype none
// ============================================================================
// Module   : tm1638_led_writer
// Purpose  : Serialises an 8-bit LED pattern onto the TM1638 STB/CLK/DIO bus.
// Revision : 1.0 - initial release
// ============================================================================
module tm1638_led_writer #(
    parameter int          CLK_DIV    = 25,
    parameter logic [2:0]  BRIGHTNESS = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] led,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio,
    output logic       busy
);

    localparam int                  c_DIV_W    = $clog2(2 * CLK_DIV);
    localparam logic [c_DIV_W-1:0]  c_HALF_END = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_GAP_END  = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0]  c_DIV_ONE  = c_DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STB_SETUP = 3'd1,
        S_BIT_LOW   = 3'd2,
        S_BIT_HIGH  = 3'd3,
        S_STB_HOLD  = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t             r_state,   w_state_next;
    logic [c_DIV_W-1:0] r_div,     w_div_next;
    logic [2:0]         r_bit,     w_bit_next;
    logic [4:0]         r_byte,    w_byte_next;
    logic [1:0]         r_frame,   w_frame_next;
    logic               r_launch,  w_launch_next;
    logic               r_pending, w_pending_next;
    logic [7:0]         r_led_q;
    logic               w_capture;
    logic               r_tm_stb,  w_stb_next;
    logic               r_tm_clk,  w_clk_next;
    logic               r_tm_dio,  w_dio_next;
    logic               r_busy,    w_busy_next;
    logic [4:0]         w_last_byte;
    logic [7:0]         w_tx_byte;

    // Frame A: data command, frame B: address + 16 grid bytes, frame C: display control.
    // Odd addresses 1,3..15 carry LED1..LED8 in bit 0, i.e. idx 2,4..16 -> led[7..0].
    function automatic logic [7:0] frame_byte(input logic [1:0] frame,
                                              input logic [4:0] idx,
                                              input logic [7:0] pat);
        frame_byte = 8'h00;
        case (frame)
            2'd0:    frame_byte = 8'h40;
            2'd1: begin
                if (idx == 5'd0)
                    frame_byte = 8'hC0;
                else if (!idx[0])
                    frame_byte = {7'b0, pat[3'(4'd8 - idx[4:1])]};
            end
            default: frame_byte = 8'h88 | {5'b0, BRIGHTNESS};
        endcase
    endfunction

    always_comb begin
        w_state_next   = r_state;
        w_div_next     = r_div;
        w_bit_next     = r_bit;
        w_byte_next    = r_byte;
        w_frame_next   = r_frame;
        w_launch_next  = r_launch;
        w_pending_next = r_pending;
        w_capture      = 1'b0;
        w_last_byte    = (r_frame == 2'd1) ? 5'd16 : 5'd0;

        case (r_state)
            S_IDLE: begin
                if (r_launch) begin
                    w_state_next  = S_STB_SETUP;
                    w_div_next    = '0;
                    w_bit_next    = 3'd0;
                    w_byte_next   = 5'd0;
                    w_frame_next  = 2'd0;
                    w_launch_next = 1'b0;
                end else if (start) begin
                    w_capture     = 1'b1;
                    w_launch_next = 1'b1;
                end
            end
            S_STB_SETUP, S_BIT_LOW, S_STB_HOLD: begin
                if (r_div == c_HALF_END) begin
                    w_div_next = '0;
                    case (r_state)
                        S_STB_SETUP: w_state_next = S_BIT_LOW;
                        S_BIT_LOW:   w_state_next = S_BIT_HIGH;
                        default:     w_state_next = S_GAP;
                    endcase
                end else begin
                    w_div_next = r_div + c_DIV_ONE;
                end
            end
            S_BIT_HIGH: begin
                if (r_div == c_HALF_END) begin
                    w_div_next = '0;
                    if (r_bit == 3'd7) begin
                        w_bit_next = 3'd0;
                        if (r_byte == w_last_byte) begin
                            w_state_next = S_STB_HOLD;
                        end else begin
                            w_byte_next  = r_byte + 5'd1;
                            w_state_next = S_BIT_LOW;
                        end
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_state_next = S_BIT_LOW;
                    end
                end else begin
                    w_div_next = r_div + c_DIV_ONE;
                end
            end
            S_GAP: begin
                if (r_div == c_GAP_END) begin
                    w_div_next = '0;
                    if (r_frame == 2'd2) begin
                        w_state_next = S_IDLE;
                        if (r_pending || start) begin
                            w_capture      = 1'b1;
                            w_pending_next = 1'b0;
                            w_launch_next  = 1'b1;
                        end
                    end else begin
                        w_frame_next = r_frame + 2'd1;
                        w_byte_next  = 5'd0;
                        w_state_next = S_STB_SETUP;
                    end
                end else begin
                    w_div_next = r_div + c_DIV_ONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // A request arriving while a refresh is in flight only queues a follow-up;
        // the captured pattern stays untouched until the current refresh ends.
        if (start && (r_state != S_IDLE || r_launch) && !w_capture)
            w_pending_next = 1'b1;

        w_busy_next = (w_state_next != S_IDLE) || (w_launch_next && r_state == S_GAP);
        w_stb_next  = (w_state_next == S_IDLE) || (w_state_next == S_GAP);
        w_clk_next  = (w_state_next != S_BIT_LOW);
        w_tx_byte   = frame_byte(w_frame_next, w_byte_next, r_led_q);

        // DIO holds through BIT_HIGH and STB_HOLD so it never moves under a high clock.
        case (w_state_next)
            S_BIT_LOW:      w_dio_next = w_tx_byte[w_bit_next];
            S_IDLE, S_GAP:  w_dio_next = 1'b1;
            default:        w_dio_next = r_tm_dio;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= 3'd0;
            r_byte    <= 5'd0;
            r_frame   <= 2'd0;
            r_launch  <= 1'b0;
            r_pending <= 1'b0;
            r_led_q   <= 8'h00;
            r_tm_stb  <= 1'b1;
            r_tm_clk  <= 1'b1;
            r_tm_dio  <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_div     <= w_div_next;
            r_bit     <= w_bit_next;
            r_byte    <= w_byte_next;
            r_frame   <= w_frame_next;
            r_launch  <= w_launch_next;
            r_pending <= w_pending_next;
            if (w_capture)
                r_led_q <= led;
            r_tm_stb  <= w_stb_next;
            r_tm_clk  <= w_clk_next;
            r_tm_dio  <= w_dio_next;
            r_busy    <= w_busy_next;
        end
    end

    assign tm_stb = r_tm_stb;
    assign tm_clk = r_tm_clk;
    assign tm_dio = r_tm_dio;
    assign busy   = r_busy;

endmodule
`default_nettype wire
